// File: rtl/pulse_chain_seq.sv
// Chained pulse sequencer: fires N_CH outputs one after another with per-channel
// prescaled pulse and delay lengths, optionally repeating the whole chain.
module pulse_chain_seq #(
    parameter int unsigned N_CH   = 16,
    parameter int unsigned CNT_W  = 17,
    parameter int unsigned MULT_W = 5,
    parameter int unsigned LOOP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [1:0]              cfg_sel,
    input  logic [CNT_W-1:0]        cfg_data,
    input  logic [LOOP_W-1:0]       repeat_cnt,
    output logic [N_CH-1:0]         ch_out,
    output logic [$clog2(N_CH)-1:0] cur_ch,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CH_W = $clog2(N_CH);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_DELAY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    dur_q [N_CH];
    logic [CNT_W-1:0]    del_q [N_CH];
    logic [MULT_W-1:0]   mpl_q [N_CH];
    logic [MULT_W-1:0]   mdl_q [N_CH];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MULT_W-1:0]   pre_q, pre_d;
    logic [LOOP_W-1:0]   rem_q, rem_d;
    logic [N_CH-1:0]     ch_out_q, ch_out_d;
    logic [CH_W-1:0]     cur_q, cur_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [N_CH-1:0]     act;
    logic                nz_found, nx_found;
    logic [CH_W-1:0]     nz_idx, nx_idx;
    logic                unit_end;
    logic [MULT_W-1:0]   reload;
    logic                adv, go_enter, go_finish;
    logic [CH_W-1:0]     tgt;

    // Configuration registers, writable only while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                dur_q[i] <= '0;
                del_q[i] <= '0;
                mpl_q[i] <= '0;
                mdl_q[i] <= '0;
            end
        end else if (cfg_we && !busy_q) begin
            case (cfg_sel)
                2'd0:    dur_q[cfg_ch] <= cfg_data;
                2'd1:    del_q[cfg_ch] <= cfg_data;
                2'd2:    mpl_q[cfg_ch] <= cfg_data[MULT_W-1:0];
                default: mdl_q[cfg_ch] <= cfg_data[MULT_W-1:0];
            endcase
        end
    end

    // A channel with zero pulse and zero delay takes no time, so find the next one that does
    always_comb begin
        nz_found = 1'b0;
        nz_idx   = '0;
        nx_found = 1'b0;
        nx_idx   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            act[i] = (dur_q[i] != '0) || (del_q[i] != '0);
        end
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (act[i]) begin
                nz_found = 1'b1;
                nz_idx   = CH_W'(i);
                if (i > int'(cur_q)) begin
                    nx_found = 1'b1;
                    nx_idx   = CH_W'(i);
                end
            end
        end
    end

    assign unit_end = (pre_q == '0) && (cnt_q == CNT_W'(1));
    assign reload   = (state_q == S_PULSE) ? mpl_q[cur_q] : mdl_q[cur_q];

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pre_d     = pre_q;
        rem_d     = rem_q;
        ch_out_d  = ch_out_q;
        cur_d     = cur_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        adv       = 1'b0;
        go_enter  = 1'b0;
        go_finish = 1'b0;
        tgt       = nz_idx;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d  = repeat_cnt;
                    busy_d = 1'b1;
                    if (nz_found) go_enter  = 1'b1;
                    else          go_finish = 1'b1;
                end
            end
            S_PULSE, S_DELAY: begin
                if (unit_end) begin
                    if (state_q == S_PULSE && del_q[cur_q] != '0) begin
                        state_d  = S_DELAY;
                        ch_out_d = '0;
                        cnt_d    = del_q[cur_q];
                        pre_d    = mdl_q[cur_q];
                    end else begin
                        adv = 1'b1;
                    end
                end else if (pre_q == '0) begin
                    pre_d = reload;
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    pre_d = pre_q - MULT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (adv) begin
            if (nx_found) begin
                go_enter = 1'b1;
                tgt      = nx_idx;
            end else if (rem_q != '0) begin
                rem_d = rem_q - LOOP_W'(1);
                if (nz_found) go_enter  = 1'b1;
                else          go_finish = 1'b1;
            end else begin
                go_finish = 1'b1;
            end
        end

        if (go_enter) begin
            cur_d = tgt;
            if (dur_q[tgt] != '0) begin
                state_d  = S_PULSE;
                ch_out_d = N_CH'(1) << tgt;
                cnt_d    = dur_q[tgt];
                pre_d    = mpl_q[tgt];
            end else begin
                state_d  = S_DELAY;
                ch_out_d = '0;
                cnt_d    = del_q[tgt];
                pre_d    = mdl_q[tgt];
            end
        end

        if (go_finish) begin
            state_d  = S_IDLE;
            ch_out_d = '0;
            cur_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
        end

        if (abort) begin
            state_d  = S_IDLE;
            ch_out_d = '0;
            cur_d    = '0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pre_q    <= '0;
            rem_q    <= '0;
            ch_out_q <= '0;
            cur_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            rem_q    <= rem_d;
            ch_out_q <= ch_out_d;
            cur_q    <= cur_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ch_out = ch_out_q;
    assign cur_ch = cur_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_pulse_chain_seq.sv
// Bench for pulse_chain_seq: table vectors, random configs against a waveform
// model built from pulse/delay arithmetic, plus abort/reset/lockout sequences.
module tb_pulse_chain_seq;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, cfg_we;
    logic [1:0]  cfg_ch, cfg_sel;
    logic [16:0] cfg_data;
    logic [7:0]  repeat_cnt;
    logic [3:0]  ch_out;
    logic [1:0]  cur_ch;
    logic        busy, done;

    pulse_chain_seq #(.N_CH(NC), .CNT_W(17), .MULT_W(5), .LOOP_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .repeat_cnt(repeat_cnt), .ch_out(ch_out), .cur_ch(cur_ch),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ch;
        logic       busy;
        logic       done;
        logic [1:0] cur;
    } obs_t;

    typedef logic [3:0][7:0] arr4_t;

    typedef struct packed {
        arr4_t       dur;
        arr4_t       del;
        arr4_t       mpl;
        arr4_t       mdl;
        logic [7:0]  rep;
        logic [15:0] exp_busy;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_dur [NC];
    int   m_del [NC];
    int   m_mpl [NC];
    int   m_mdl [NC];
    obs_t exp_q [$];
    vec_t vt [6];

    function automatic arr4_t pk(input int a, input int b, input int c, input int d);
        arr4_t r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        return r;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ch = ch_out; o.busy = busy; o.done = done; o.cur = cur_ch;
        return o;
    endfunction

    task automatic check(input string nm, input obs_t a, input obs_t e);
        n_cmp++;
        if (a.ch !== e.ch || a.busy !== e.busy || a.done !== e.done ||
            (e.ch != 4'b0 && a.cur !== e.cur)) begin
            n_bad++;
            $display("FAIL %s: got ch=%b busy=%b done=%b cur=%0d, want ch=%b busy=%b done=%b cur=%0d",
                     nm, a.ch, a.busy, a.done, a.cur, e.ch, e.busy, e.done, e.cur);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    // Expected waveform: each pass lays out every channel's pulse then its delay
    task automatic build_model(input int rep, input bit tail_idle);
        obs_t o;
        exp_q.delete();
        for (int p = 0; p <= rep; p++) begin
            for (int c = 0; c < NC; c++) begin
                for (int k = 0; k < m_dur[c] * (m_mpl[c] + 1); k++) begin
                    o.ch = 4'(1 << c); o.busy = 1'b1; o.done = 1'b0; o.cur = 2'(c);
                    exp_q.push_back(o);
                end
                for (int k = 0; k < m_del[c] * (m_mdl[c] + 1); k++) begin
                    o.ch = 4'b0; o.busy = 1'b1; o.done = 1'b0; o.cur = 2'(c);
                    exp_q.push_back(o);
                end
            end
        end
        o = '0; o.done = 1'b1;
        exp_q.push_back(o);
        if (tail_idle) begin
            o = '0;
            exp_q.push_back(o);
        end
    endtask

    task automatic write_cfg(input int ch, input int sel, input int data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_sel = 2'(sel); cfg_data = 17'(data);
        case (sel)
            0: m_dur[ch] = data;
            1: m_del[ch] = data;
            2: m_mpl[ch] = data;
            default: m_mdl[ch] = data;
        endcase
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_vec(input vec_t v);
        for (int c = 0; c < NC; c++) begin
            write_cfg(c, 0, int'(v.dur[c]));
            write_cfg(c, 1, int'(v.del[c]));
            write_cfg(c, 2, int'(v.mpl[c]));
            write_cfg(c, 3, int'(v.mdl[c]));
        end
    endtask

    // One launch compared cycle by cycle; optional illegal start/cfg write mid-run
    task automatic run_seq(input string nm, input int rep, input int disturb_at,
                           input bit tail_idle, output int busy_cycles);
        obs_t a;
        build_model(rep, tail_idle);
        busy_cycles = 0;
        @(negedge clk);
        start = 1'b1; repeat_cnt = 8'(rep);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start = 1'b0; cfg_we = 1'b0;
            a = sample();
            if (a.busy) busy_cycles++;
            check($sformatf("%s cyc%0d", nm, i), a, exp_q[i]);
            if (i == disturb_at) begin
                start = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 2'd0; cfg_data = 17'd7;
            end
        end
        start = 1'b0; cfg_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bc;
        bit   seen;
        obs_t a, z;
        z = '0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_sel = '0; cfg_data = '0; repeat_cnt = '0;
        for (int c = 0; c < NC; c++) begin
            m_dur[c] = 0; m_del[c] = 0; m_mpl[c] = 0; m_mdl[c] = 0;
        end

        vt[0] = '{dur: pk(3,2,1,4), del: pk(1,1,1,1), mpl: pk(0,0,0,0), mdl: pk(0,0,0,0), rep: 8'd0, exp_busy: 16'd14};
        vt[1] = '{dur: pk(2,1,1,1), del: pk(2,0,0,0), mpl: pk(3,0,0,0), mdl: pk(1,0,0,0), rep: 8'd0, exp_busy: 16'd15};
        vt[2] = '{dur: pk(2,0,3,1), del: pk(1,0,0,2), mpl: pk(0,0,0,0), mdl: pk(0,0,0,0), rep: 8'd0, exp_busy: 16'd9};
        vt[3] = '{dur: pk(1,2,1,1), del: pk(0,1,0,1), mpl: pk(0,0,0,0), mdl: pk(0,0,0,0), rep: 8'd2, exp_busy: 16'd21};
        vt[4] = '{dur: pk(1,1,1,1), del: pk(0,0,0,0), mpl: pk(1,2,0,4), mdl: pk(0,0,0,0), rep: 8'd1, exp_busy: 16'd22};
        vt[5] = '{dur: pk(0,0,0,5), del: pk(0,0,3,0), mpl: pk(0,0,0,0), mdl: pk(0,0,2,0), rep: 8'd0, exp_busy: 16'd14};

        repeat (3) @(negedge clk);
        #1; check("reset_state", sample(), z);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); check("post_reset_idle", sample(), z);

        for (int v = 0; v < 6; v++) begin
            load_vec(vt[v]);
            run_seq($sformatf("vec%0d", v), int'(vt[v].rep), -1, 1'b1, bc);
            check_int($sformatf("vec%0d busy_len", v), bc, int'(vt[v].exp_busy));
        end

        // Back-to-back launches: next start right after the done cycle
        load_vec(vt[0]);
        run_seq("b2b_a", 0, -1, 1'b0, bc);
        run_seq("b2b_b", 0, -1, 1'b1, bc);
        check_int("b2b_b busy_len", bc, 14);

        // start and cfg write while busy must neither restart nor modify config
        run_seq("locked", 0, 3, 1'b1, bc);
        run_seq("locked_after", 0, -1, 1'b1, bc);
        check_int("locked_after busy_len", bc, 14);

        // Abort during channel 2 pulse
        @(negedge clk); start = 1'b1; repeat_cnt = 8'd0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); start = 1'b0;
            if (ch_out == 4'b0100) seen = 1'b1;
        end
        check_int("abort reached ch2", int'(seen), 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort outputs", sample(), z);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy || ch_out != 4'b0) seen = 1'b1;
        end
        check_int("abort no done", int'(seen), 0);
        run_seq("after_abort", 0, -1, 1'b1, bc);

        // Abort beats start in the same cycle
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("abort_over_start", sample(), z);

        // Randomized configurations against the model
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < NC; c++) begin
                write_cfg(c, 0, int'($urandom_range(0, 4)));
                write_cfg(c, 1, int'($urandom_range(0, 3)));
                write_cfg(c, 2, int'($urandom_range(0, 2)));
                write_cfg(c, 3, int'($urandom_range(0, 2)));
            end
            run_seq($sformatf("rand%0d", r), int'($urandom_range(0, 2)), -1, 1'b1, bc);
        end

        // Reset mid-run clears outputs at once and wipes configuration
        load_vec(vt[0]);
        @(negedge clk); start = 1'b1; repeat_cnt = 8'd1;
        repeat (4) begin @(negedge clk); start = 1'b0; end
        rst_n = 1'b0;
        #1; check("reset_midrun", sample(), z);
        for (int c = 0; c < NC; c++) begin
            m_dur[c] = 0; m_del[c] = 0; m_mpl[c] = 0; m_mdl[c] = 0;
        end
        @(negedge clk); rst_n = 1'b1;
        run_seq("cfg_cleared", 0, -1, 1'b1, bc);
        check_int("cfg_cleared busy_len", bc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_chain_seq.md
PULSE_CHAIN_SEQ -- requirements
Module: pulse_chain_seq

Interface
REQ-001 SHALL have parameter N_CH, default 16: number of chained output channels (2..32).
REQ-002 SHALL have parameter CNT_W, default 17: width of duration and delay counts.
REQ-003 SHALL have parameter MULT_W, default 5: width of per-channel prescaler multipliers.
REQ-004 SHALL have parameter LOOP_W, default 8: width of the repeat count.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1: one-cycle launch request.
REQ-008 SHALL have port abort, input, 1: stop the sequence immediately.
REQ-009 SHALL have port cfg_we, input, 1: configuration write strobe.
REQ-010 SHALL have port cfg_ch, input, $clog2(N_CH): target channel of the configuration write.
REQ-011 SHALL have port cfg_sel, input, 2: 0=duration, 1=delay, 2=pulse multiplier, 3=delay multiplier.
REQ-012 SHALL have port cfg_data, input, CNT_W: write data; multiplier writes use the low MULT_W bits.
REQ-013 SHALL have port repeat_cnt, input, LOOP_W: extra passes, sampled at start.
REQ-014 SHALL have port ch_out, output, N_CH: registered pulse outputs.
REQ-015 SHALL have port cur_ch, output, $clog2(N_CH): index of the active channel; 0 when idle.
REQ-016 SHALL have port busy, output, 1: high from the accepted start until return to IDLE.
REQ-017 SHALL have port done, output, 1: one-cycle pulse at normal completion.

Function
REQ-018 SHALL hold per-channel registers: DUR[CNT_W], DEL[CNT_W], MPL[MULT_W], MDL[MULT_W].
REQ-019 SHALL write the register selected by cfg_sel/cfg_ch on a cycle with cfg_we=1 and busy=0.
REQ-020 SHALL ignore cfg_we while busy=1; configuration is locked during a run.
REQ-021 SHALL implement the FSM states IDLE, PULSE, DELAY, using one shared cycle counter and one shared prescaler.
REQ-022 SHALL accept start only in IDLE; start while busy has no effect.
REQ-023 SHALL, on an accepted start at edge k, sample repeat_cnt, set cur_ch=0, and enter PULSE for channel 0 with ch_out[0]=1 from edge k+1.
REQ-024 SHALL keep channel c high for exactly DUR[c]*(MPL[c]+1) clocks, then drive it low and enter DELAY.
REQ-025 SHALL hold DELAY for exactly DEL[c]*(MDL[c]+1) clocks with all outputs low.
REQ-026 SHALL make DEL[c]=0 produce zero delay: channel c+1 rises on the cycle after channel c falls.
REQ-027 SHALL skip a channel with DUR[c]=0 (no pulse) while still applying its delay.
REQ-028 SHALL have at most one ch_out bit high in any cycle.
REQ-029 SHALL, after the delay of channel N_CH-1, restart at channel 0 if the remaining pass count is nonzero (decrementing it); repeat_cnt=R gives R+1 passes.
REQ-030 SHALL, after the final pass, assert done for exactly one cycle, clear busy in that same cycle, and return to IDLE.
REQ-031 SHALL have no idle gap between passes beyond the configured delays.
REQ-032 SHALL, on abort=1 in any state, drive ch_out=0, busy=0 and cur_ch=0 and enter IDLE on the next edge, with no done.
REQ-033 SHALL give abort priority over start in the same cycle.
REQ-034 SHALL use counter arithmetic at full width, with no wrap: maximum pulse length (2^CNT_W-1)*2^MULT_W clocks.
REQ-035 SHALL accept a start in the cycle immediately after done.

Reset
REQ-036 SHALL, while rst_n=0, force FSM=IDLE, ch_out=0, cur_ch=0, busy=0, done=0, and all counters and all DUR/DEL/MPL/MDL registers to 0.
REQ-037 SHALL treat reset asserted mid-run like abort: outputs low, no done, and configuration also cleared.
REQ-038 SHALL take no action on the first edge after rst_n deasserts; start is honoured from that edge onward.

Verification
REQ-039 SHALL verify: N_CH=4, DUR={3,2,1,4}, DEL=1, all mults 0, R=0 -> ch0 high for 3 clocks, 1 low, ch1 high for 2 clocks, ..., done one clock after ch3's delay ends.
REQ-040 SHALL verify: DUR[0]=2, MPL[0]=3 -> ch0 high for exactly 8 clocks; DEL[0]=2, MDL[0]=1 -> gap of 4 clocks.
REQ-041 SHALL verify: DUR[1]=0, DEL[1]=0 -> ch1 never rises, and ch2 rises on the clock after ch0's delay ends.
REQ-042 SHALL verify: R=2 -> three identical passes, busy held continuously, and done exactly once.
REQ-043 SHALL verify: abort during ch2 pulse -> all outputs 0 on the next clock, no done; a new start is then accepted.
REQ-044 SHALL verify: cfg_we or start while busy -> no register change and no restart; rst_n low mid-run -> outputs 0 immediately and config reads back as 0.
